// File: rtl/regslv_native_resp.sv
// regslv_native_resp: register-bank responder returning a fixed-latency ack per request, with per-register hardware write ports
module regslv_native_resp #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM = 8,
  parameter int ACK_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] INVALID_DATA = 32'hDEADBEEF,
  parameter logic [REG_NUM*DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          upstream__req_vld,
  output logic                          upstream__ack_vld,
  input  logic [ADDR_WIDTH-1:0]         upstream__addr,
  input  logic                          upstream__wr_en,
  input  logic                          upstream__rd_en,
  input  logic [DATA_WIDTH-1:0]         upstream__wr_data,
  output logic [DATA_WIDTH-1:0]         upstream__rd_data,
  input  logic [REG_NUM-1:0]            hw__wr_vld,
  input  logic [REG_NUM*DATA_WIDTH-1:0] hw__wr_data,
  output logic [REG_NUM*DATA_WIDTH-1:0] hw__reg_value,
  output logic                          err_pulse
);
  localparam int IW = $clog2(REG_NUM);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [IW-1:0] idx_q;
  logic wr_q, rd_q, err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] regs [REG_NUM];
  logic dec_err, ack, sw_wr;

  assign dec_err = (upstream__addr[1:0] != 2'b00) ||
                   (upstream__addr >= ADDR_WIDTH'(4 * REG_NUM)) ||
                   (upstream__wr_en && upstream__rd_en);
  assign ack = state == ACK;
  assign sw_wr = ack && wr_q && !err_q;
  assign upstream__ack_vld = ack;
  assign err_pulse = ack && err_q;
  assign upstream__rd_data = !ack ? '0 : err_q ? INVALID_DATA : rd_q ? regs[idx_q] : '0;

  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: if (upstream__req_vld) begin
        state_nxt = (ACK_LATENCY == 1) ? ACK : WAIT;
        cnt_nxt = 4'(ACK_LATENCY - 2);
      end
      WAIT: begin
        state_nxt = (cnt == 4'd0) ? ACK : WAIT;
        cnt_nxt = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
    if (!rst && state == IDLE && upstream__req_vld) begin
      idx_q <= upstream__addr[IW+1:2];
      wr_q <= upstream__wr_en;
      rd_q <= upstream__rd_en;
      err_q <= dec_err;
      wdata_q <= upstream__wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_NUM; i++)
      if (rst) regs[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      else if (hw__wr_vld[i]) regs[i] <= hw__wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    if (!rst && sw_wr) regs[idx_q] <= wdata_q;
  end

  for (genvar i = 0; i < REG_NUM; i++) begin : g_out
    assign hw__reg_value[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end
endmodule

// File: tb/tb_regslv_native_resp.sv
// tb_regslv_native_resp: checks four responders of different ack latencies against a cycle-indexed behavioural model
module tb_regslv_native_resp;
  localparam int LAT [4] = '{1, 2, 4, 5};
  localparam logic [255:0] RV = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
  logic clk = 1'b0;
  logic rst, req, wr, rd;
  logic [63:0] addr;
  logic [31:0] wdata;
  logic [7:0] hwv_in;
  logic [255:0] hwd;
  logic ack [4];
  logic err [4];
  logic [31:0] rdd [4];
  logic [255:0] hwo [4];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    regslv_native_resp #(.ACK_LATENCY(LAT[k]), .RESET_VAL(RV)) dut (
      .clk(clk),
      .rst(rst),
      .upstream__req_vld(req),
      .upstream__ack_vld(ack[k]),
      .upstream__addr(addr),
      .upstream__wr_en(wr),
      .upstream__rd_en(rd),
      .upstream__wr_data(wdata),
      .upstream__rd_data(rdd[k]),
      .hw__wr_vld(hwv_in),
      .hw__wr_data(hwd),
      .hw__reg_value(hwo[k]),
      .err_pulse(err[k])
    );
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  bit pend [4];
  int ack_at [4];
  logic [2:0] pidx [4];
  bit pwr [4], prd [4], perr [4];
  logic [31:0] pdat [4];
  logic [31:0] mreg [4][8];

  initial begin
    bit armed, eack, busy;
    logic [31:0] erd;
    logic [255:0] ehw;
    int cyc;
    armed = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        eack = pend[k] && ack_at[k] == cyc;
        erd = !eack ? 32'h0 : perr[k] ? 32'hDEADBEEF : prd[k] ? mreg[k][pidx[k]] : 32'h0;
        for (int i = 0; i < 8; i++) ehw[i*32 +: 32] = mreg[k][i];
        if (armed) begin
          chk($sformatf("L%0d ack cyc%0d", LAT[k], cyc), 256'(ack[k]), 256'(eack));
          chk($sformatf("L%0d err cyc%0d", LAT[k], cyc), 256'(err[k]), 256'(eack && perr[k]));
          chk($sformatf("L%0d rd_data cyc%0d", LAT[k], cyc), 256'(rdd[k]), 256'(erd));
          chk($sformatf("L%0d reg_value cyc%0d", LAT[k], cyc), hwo[k], ehw);
        end
        if (rst) begin
          pend[k] = 0;
          for (int i = 0; i < 8; i++) mreg[k][i] = 32'hA0 + 32'(i);
        end else begin
          busy = pend[k];
          for (int i = 0; i < 8; i++) if (hwv_in[i]) mreg[k][i] = hwd[i*32 +: 32];
          if (eack && pwr[k] && !perr[k]) mreg[k][pidx[k]] = pdat[k];
          if (eack) pend[k] = 0;
          if (!busy && req) begin
            pend[k] = 1;
            ack_at[k] = cyc + LAT[k];
            pidx[k] = 3'(addr >> 2);
            perr[k] = (addr % 4 != 0) || (addr >= 32) || (wr && rd);
            pwr[k] = wr;
            prd[k] = rd;
            pdat[k] = wdata;
          end
        end
      end
      if (rst) armed = 1;
      cyc++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick;
  endtask

  task automatic issue(input logic [63:0] a, input logic w, input logic r, input logic [31:0] d);
    req = 1;
    addr = a;
    wr = w;
    rd = r;
    wdata = d;
    tick;
    req = 0;
    addr = '0;
    wr = 0;
    rd = 0;
    wdata = '0;
  endtask

  initial begin
    rst = 1;
    req = 0;
    wr = 0;
    rd = 0;
    addr = '0;
    wdata = '0;
    hwv_in = '0;
    hwd = '0;
    tick;
    tick;
    rst = 0;
    chk("reset reg_value", hwo[1], RV);
    idle(2);
    issue(64'h4, 0, 1, 0);
    chk("read t+1 ack", 256'(ack[1]), 0);
    chk("read t+1 rd_data", 256'(rdd[1]), 0);
    tick;
    chk("read t+2 ack", 256'(ack[1]), 1);
    chk("read t+2 rd_data", 256'(rdd[1]), 32'hA1);
    chk("read t+2 err", 256'(err[1]), 0);
    tick;
    chk("read t+3 rd_data", 256'(rdd[1]), 0);
    idle(6);
    issue(64'h8, 1, 0, 32'h12345678);
    tick;
    chk("write before commit", 256'(hwo[1][95:64]), 32'hA2);
    chk("write ack rd_data", 256'(rdd[1]), 0);
    tick;
    chk("write reg_value", 256'(hwo[1][95:64]), 32'h12345678);
    idle(5);
    issue(64'h8, 0, 1, 0);
    tick;
    chk("readback", 256'(rdd[1]), 32'h12345678);
    idle(5);
    issue(64'h20, 0, 1, 0);
    tick;
    chk("range err rd_data", 256'(rdd[1]), 32'hDEADBEEF);
    chk("range err pulse", 256'(err[1]), 1);
    idle(5);
    issue(64'h6, 0, 1, 0);
    tick;
    chk("misalign err rd_data", 256'(rdd[1]), 32'hDEADBEEF);
    idle(5);
    issue(64'h0, 1, 1, 32'hFFFFFFFF);
    idle(6);
    chk("wr+rd err reg0", 256'(hwo[1][31:0]), 32'hA0);
    issue(64'h1_0000_0004, 0, 1, 0);
    tick;
    chk("high addr err pulse", 256'(err[1]), 1);
    idle(5);
    issue(64'hC, 1, 0, 32'hAAAA0000);
    tick;
    hwv_in = 8'h18;
    hwd[127:96] = 32'h5555;
    hwd[159:128] = 32'h77;
    tick;
    hwv_in = '0;
    chk("collision sw wins", 256'(hwo[1][127:96]), 32'hAAAA0000);
    chk("collision other hw", 256'(hwo[1][159:128]), 32'h77);
    chk("later hw overwrites L1", 256'(hwo[0][127:96]), 32'h5555);
    idle(4);
    issue(64'hC, 0, 0, 0);
    tick;
    chk("noop ack", 256'(ack[1]), 1);
    chk("noop rd_data", 256'(rdd[1]), 0);
    idle(5);
    issue(64'h0, 0, 1, 0);
    tick;
    issue(64'h4, 0, 1, 0);
    tick;
    tick;
    chk("L5 ack t+5", 256'(ack[3]), 1);
    chk("L5 data t+5", 256'(rdd[3]), 32'hA0);
    tick;
    issue(64'h8, 0, 1, 0);
    idle(3);
    chk("L5 no ack t+10", 256'(ack[3]), 0);
    tick;
    chk("L5 ack t+11", 256'(ack[3]), 1);
    chk("L5 data t+11", 256'(rdd[3]), 32'h12345678);
    idle(4);
    issue(64'h10, 1, 0, 32'h0BAD0000);
    tick;
    rst = 1;
    tick;
    rst = 0;
    tick;
    chk("L4 dropped ack", 256'(ack[2]), 0);
    chk("L4 reg kept reset", 256'(hwo[2][159:128]), 32'hA4);
    issue(64'h10, 0, 1, 0);
    idle(3);
    chk("L4 post-reset ack", 256'(ack[2]), 1);
    chk("L4 post-reset data", 256'(rdd[2]), 32'hA4);
    idle(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
